// File: rtl/cgra_vec_pkg.sv
// Shared types for the streaming CGRA vector add/sub block: arithmetic modes,
// control FSM states and a lane packing helper.
package cgra_vec_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_SADD = 2'b10,
    MODE_SSUB = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Lane k of a packed beat lives at bits [k*width +: width].
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/cgra_sync_fifo.sv
// Single-clock FIFO with count-based full/empty flags and a head read
// straight from the storage registers.
module cgra_sync_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_q];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cgra_vec_addsub_stream.sv
// Streams one VEC_LEN-element job through per-lane add/sub (wrap or unsigned
// saturate), buffers results in a FIFO and counts overflowing lanes.
module cgra_vec_addsub_stream
  import cgra_vec_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LANES      = 4,
  parameter int VEC_LEN    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*WIDTH-1:0]       in_a,
  input  logic [LANES*WIDTH-1:0]       in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*WIDTH-1:0]       out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(VEC_LEN+1)-1:0] ovf_count
);

  localparam int BEATS = VEC_LEN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OW    = $clog2(VEC_LEN + 1);
  localparam int PW    = $clog2(LANES + 1);
  localparam int DW    = LANES * WIDTH;

  if (VEC_LEN % LANES != 0) begin : g_bad_len
    $error("VEC_LEN must be a multiple of LANES");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  state_e          state_q;
  mode_e           mode_q;
  logic [BW-1:0]   beat_q;
  logic [OW-1:0]   ovf_q;
  logic [OW-1:0]   ovf_d;
  logic [DW-1:0]   res;
  logic [LANES-1:0] lane_ovf;
  logic [PW-1:0]   pop_cnt;
  logic [OW:0]     ovf_sum;
  logic            in_fire;
  logic            out_fire;
  logic            last_beat;
  logic            fifo_full;
  logic            fifo_empty;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int LSB = lane_lsb(k, WIDTH);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] lane_res;

    assign a    = in_a[LSB +: WIDTH];
    assign b    = in_b[LSB +: WIDTH];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    // Top bit of the widened result is carry for add, borrow for sub.
    assign lane_ovf[k] = (mode_q == MODE_ADD || mode_q == MODE_SADD) ? sum[WIDTH] : diff[WIDTH];

    always_comb begin
      lane_res = sum[WIDTH-1:0];
      case (mode_q)
        MODE_SUB:  lane_res = diff[WIDTH-1:0];
        MODE_SADD: lane_res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        MODE_SSUB: lane_res = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
        default:   lane_res = sum[WIDTH-1:0];
      endcase
    end

    assign res[LSB +: WIDTH] = lane_res;
  end

  always_comb begin
    pop_cnt = '0;
    for (int k = 0; k < LANES; k++) pop_cnt = pop_cnt + PW'(lane_ovf[k]);
  end

  assign ovf_sum = {1'b0, ovf_q} + (OW+1)'(pop_cnt);
  assign ovf_d   = (ovf_sum > (OW+1)'(VEC_LEN)) ? OW'(VEC_LEN) : ovf_sum[OW-1:0];

  assign in_ready  = (state_q == RUN) & ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_beat = (beat_q == BW'(BEATS - 1));

  cgra_sync_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_fire),
    .pop   (out_fire),
    .wdata ({last_beat, res}),
    .rdata ({out_last, out_data}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Job control; mode is captured once so mid-job changes have no effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_ADD;
      beat_q  <= '0;
      ovf_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          mode_q  <= mode_e'(mode);
          beat_q  <= '0;
          ovf_q   <= '0;
        end
        RUN: if (in_fire) begin
          ovf_q <= ovf_d;
          if (last_beat) state_q <= DRAIN;
          else           beat_q  <= beat_q + 1'b1;
        end
        DRAIN: if (out_fire && out_last) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign ovf_count = ovf_q;

endmodule

// File: tb/tb_cgra_vec_addsub_stream.sv
// Directed table-driven bench for cgra_vec_addsub_stream with hand-written
// stall, mid-job start and mid-job reset sequences.
module tb_cgra_vec_addsub_stream;

  localparam int W     = 32;
  localparam int L     = 4;
  localparam int VL    = 32;
  localparam int DEP   = 4;
  localparam int BEATS = VL / L;
  localparam int DW    = L * W;
  localparam int NV    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [5:0]    ovf_count;

  cgra_vec_addsub_stream #(
    .WIDTH(W), .LANES(L), .VEC_LEN(VL), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic        ramp;     // a=i, b=32-i per element instead of constants
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_ovf;
    int          stall;    // out_ready held low for this many cycles
    int          glitch;   // cycle at which a stray start is pulsed (0 = none)
  } vec_t;

  vec_t tbl[NV];
  logic [DW:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_beat(input vec_t v, input int bt);
    for (int k = 0; k < L; k++) begin
      if (v.ramp) begin
        in_a[k*W +: W] = 32'(bt * L + k);
        in_b[k*W +: W] = 32'(32 - (bt * L + k));
      end else begin
        in_a[k*W +: W] = v.a;
        in_b[k*W +: W] = v.b;
      end
    end
  endtask

  // Called at a negedge while the DUT is IDLE; returns at a negedge in IDLE.
  task automatic run_job(input vec_t v, input int id);
    int cyc;
    int beat;
    int got;
    exp_q.delete();
    for (int bt = 0; bt < BEATS; bt++) exp_q.push_back({(bt == BEATS - 1), {L{v.exp_res}}});
    start = 1'b1;
    mode  = v.mode;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; beat = 0; got = 0;
    while (got < BEATS && cyc < 400) begin
      cyc++;
      if (v.glitch != 0 && cyc == v.glitch) begin
        start = 1'b1;
        mode  = ~v.mode;
      end else begin
        start = 1'b0;
      end
      out_ready = (cyc <= v.stall) ? 1'b0 : 1'b1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("job%0d_extra_beat", id), 1, 0);
        end else if (out_ready) begin
          chk($sformatf("job%0d_beat%0d", id, got), {out_last, out_data}, exp_q.pop_front());
          got++;
        end else begin
          chk($sformatf("job%0d_stall_hold", id), {out_last, out_data}, exp_q[0]);
        end
      end
      if (beat < BEATS) begin
        in_valid = 1'b1;
        drive_beat(v, beat);
        if (in_ready) beat++;
      end else begin
        in_valid = 1'b0;
      end
      if (v.stall >= 6 && cyc == v.stall) begin
        chk($sformatf("job%0d_buffered_beats", id), beat, DEP);
        chk($sformatf("job%0d_in_ready_full", id), in_ready, 0);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 400) chk($sformatf("job%0d_timeout", id), got, BEATS);
    chk($sformatf("job%0d_done_pulse", id), {done, busy, out_valid}, 3'b100);
    chk($sformatf("job%0d_ovf", id), ovf_count, v.exp_ovf);
    @(negedge clk);
    chk($sformatf("job%0d_done_low", id), {done, busy}, 2'b00);
    chk($sformatf("job%0d_ovf_hold", id), ovf_count, v.exp_ovf);
  endtask

  task automatic reset_mid_job();
    int cyc;
    int beat;
    logic done_seen;
    start = 1'b1;
    mode  = 2'b00;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    cyc = 0; beat = 0;
    while (beat < 4 && cyc < 50) begin
      cyc++;
      in_valid = 1'b1;
      drive_beat(tbl[0], beat);
      if (in_ready) beat++;
      @(negedge clk);
    end
    chk("rst_pre_busy", busy, 1);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_flags", {done, in_ready, out_last}, 3'b000);
    chk("rst_mid_out_data", out_data, 0);
    chk("rst_mid_ovf", ovf_count, 0);
    out_ready = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || out_valid) done_seen = 1'b1;
    end
    chk("rst_mid_no_done_or_data", done_seen, 0);
  endtask

  initial begin
    //            mode  ramp a             b      exp_res       ovf stall glitch
    tbl[0] = '{2'b00, 1'b1, 32'h0,        32'h0, 32'h20,       0,  0,  0};
    tbl[1] = '{2'b00, 1'b1, 32'h0,        32'h0, 32'h20,       0,  10, 0};
    tbl[2] = '{2'b01, 1'b0, 32'h5,        32'h7, 32'hFFFFFFFE, 32, 0,  0};
    tbl[3] = '{2'b11, 1'b0, 32'h5,        32'h7, 32'h0,        32, 0,  0};
    tbl[4] = '{2'b10, 1'b0, 32'hFFFFFFF0, 32'h20, 32'hFFFFFFFF, 32, 0, 0};
    tbl[5] = '{2'b00, 1'b0, 32'hFFFFFFF0, 32'h20, 32'h10,      32, 0,  0};
    tbl[6] = '{2'b10, 1'b0, 32'h1,        32'h2, 32'h3,        0,  0,  3};
    tbl[7] = '{2'b01, 1'b0, 32'h7,        32'h5, 32'h2,        0,  3,  0};

    reset = 1'b1; start = 1'b0; mode = 2'b00; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ready_valid", {in_ready, out_valid, out_last}, 3'b000);
    chk("reset_busy_done", {busy, done}, 2'b00);
    chk("reset_out_data", out_data, 0);
    chk("reset_ovf", ovf_count, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    for (int i = 0; i < NV; i++) run_job(tbl[i], i);
    reset_mid_job();
    run_job(tbl[0], 100);
    run_job(tbl[2], 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
